inst_encoder: RTL

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Purpose  : Packs instruction field tuples (N/R/I/S formats) into 32-bit
//            words and writes them as a burst into instruction memory,
//            starting at a programmable base address with address wrap.
// Revision : 1.0  initial release
// ============================================================================
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_dr,
    input  logic [4:0]        in_sa,
    input  logic [4:0]        in_sb,
    input  logic [14:0]       in_imm,
    input  logic [4:0]        in_sh,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   count
);

    // Instruction formats as carried on in_fmt
    localparam logic [1:0] c_fmt_n = 2'b00;
    localparam logic [1:0] c_fmt_r = 2'b01;
    localparam logic [1:0] c_fmt_i = 2'b10;
    localparam logic [1:0] c_fmt_s = 2'b11;

    localparam logic [ADDR_W-1:0] c_addr_max = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_len_zero = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   c_len_one  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remaining;
    logic [ADDR_W:0]   r_count;
    logic              r_wrapped;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic [14:0]       w_low;
    logic [31:0]       w_word;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_addr_wraps;
    logic [ADDR_W:0]   w_rem_next;

    // Field packing: the low 15 bits depend on format, unused fields are dropped
    always_comb begin
        w_low = 15'd0;
        case (in_fmt)
            c_fmt_n: w_low = 15'd0;
            c_fmt_r: w_low = {in_sb, 10'd0};
            c_fmt_i: w_low = in_imm;
            c_fmt_s: w_low = {in_sb, 5'd0, in_sh};
            default: w_low = 15'd0;
        endcase
        w_word = {in_opcode, in_dr, in_sa, w_low};
    end

    // Handshake is combinational on abort so an aborting cycle never accepts;
    // rst also blocks acceptance because it overrides everything at the edge
    assign w_in_ready = (r_state == S_RUN) && (r_remaining != c_len_zero)
                        && !abort && !rst;
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = (r_remaining == c_len_one);

    // Address and remaining-count arithmetic for the accept path
    assign w_addr_next  = r_addr + c_addr_one;
    assign w_addr_wraps = (r_addr == c_addr_max);
    assign w_rem_next   = r_remaining - c_len_one;

    // Burst control FSM together with the registered memory write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted tuple
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= '0;
                        r_wrapped <= 1'b0;
                        if (length != c_len_zero) begin
                            r_addr      <= base_addr;
                            r_remaining <= length;
                            r_state     <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_word;
                        r_addr      <= w_addr_next;
                        r_count     <= r_count + c_len_one;
                        r_remaining <= w_rem_next;
                        if (w_addr_wraps) begin
                            r_wrapped <= 1'b1;
                        end
                        // Final word: DONE lines up with its write cycle
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign wrapped   = r_wrapped;
    assign count     = r_count;

endmodule
`default_nettype wire
